muldiv_wb_arbiter: RTL and testbench
====================================

# muldiv_wb_arbiter

Writeback stage directly downstream of the multiply/divide execution unit. Captures the unstallable mul and div result streams into per-source FIFOs and merges them onto one result-bus port with a valid/ready handshake. Issue throttling is credit-based, so a result never arrives at a full FIFO.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries per source FIFO; power of two, ≥2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mul_issue_i  in  1  a multiply is issued to the mul/div unit this cycle; consumes one mul credit.
- div_issue_i  in  1  a divide is issued this cycle; consumes one div credit.
- mul_valid_i  in  1  multiply result arrives from the unit.
- mul_result_i  in  64  multiply result.
- mul_dest_phys_i  in  7  multiply destination physical register.
- mul_rob_idx_i  in  8  multiply ROB index.
- div_valid_i, div_result_i, div_dest_phys_i, div_rob_idx_i  in  1/64/7/8  same fields for divide.
- mul_can_issue_o  out  1  mul credit available.
- div_can_issue_o  out  1  div credit available.
- wb_valid_o  out  1  writeback entry presented.
- wb_ready_i  in  1  result bus accepts the entry.
- wb_result_o  out  64  presented result.
- wb_dest_phys_o  out  7  presented destination register.
- wb_rob_idx_o  out  8  presented ROB index.
- wb_src_o  out  1  source of the presented entry: 0 = mul, 1 = div.
- err_o  out  1  sticky error flag.

## Operation
- Per source: FIFO of FIFO_DEPTH entries {result, dest, rob}, with wr_ptr and rd_ptr of log2(FIFO_DEPTH) bits that wrap modulo depth, and a count of log2(FIFO_DEPTH)+1 bits.
- Per source: credit counter `used`, width log2(FIFO_DEPTH)+1, covering issued-but-not-written-back entries.
  - issue only → +1; pop only → −1; both in the same cycle → unchanged.
  - X_can_issue_o = (used < FIFO_DEPTH), decoded from registered `used`.
- Arrival (X_valid_i): write the head fields into the FIFO at wr_ptr.
- Error cases, each setting err_o (sticky until reset):
  - Arrival while that FIFO is full: entry dropped, pointers unchanged.
  - Issue while X_can_issue_o = 0: `used` saturates at FIFO_DEPTH.
  - Pop when `used` = 0: `used` stays at 0.
- Selection:
  - Only one FIFO non-empty → present that FIFO's head.
  - Both non-empty → round-robin. rr_last records the source of the last accepted transfer; the other source wins. rr_last resets to 1 (div), so mul wins the first tie.
- Lock: when wb_valid_o = 1 and wb_ready_i = 0, a lock register holds the selected source. Presented source and fields stay frozen until acceptance, even if the other FIFO gains an entry. Lock clears on acceptance.
- Transfer occurs when wb_valid_o & wb_ready_i:
  - pop the selected FIFO (rd_ptr+1, count−1);
  - decrement that source's `used`;
  - update rr_last.
- Mul and div may arrive, and a pop may occur, in the same cycle. Push and pop on the same FIFO in one cycle leaves count unchanged and is legal when full, because the pop frees a slot first.

## Timing
- Reset values: wb_valid_o 0; wb_result_o, wb_dest_phys_o, wb_rob_idx_o, wb_src_o 0; mul_can_issue_o and div_can_issue_o 1; err_o 0.
- Reset clears all pointers, counts, `used`, lock, and sets rr_last to 1. Reset mid-operation discards all buffered and in-flight bookkeeping.
- Arrival at cycle N → wb_valid_o earliest at cycle N+1. No input-to-output bypass.
- wb_* outputs depend on FIFO heads, lock and rr_last only; no combinational path from wb_ready_i to wb_* outputs.
- Credit return: a pop at cycle N raises X_can_issue_o at N+1.
- Issue at cycle N lowers X_can_issue_o at N+1 when `used` reaches FIFO_DEPTH.
- Throughput: one writeback per cycle while wb_ready_i = 1.

## Test plan
- Single mul: issue, then mul_valid_i with result 0x1234, dest 5, rob 9 at cycle N → at N+1 wb_valid_o=1, wb_src_o=0, fields match. With wb_ready_i=1, wb_valid_o=0 at N+2.
- Simultaneous arrival: mul (rob 1) and div (rob 2) in the same cycle, ready held high → mul accepted first, then div. Repeat the pair → mul, div again.
- Backpressure lock: div head presented with ready=0; mul arrives while stalled → div fields stay stable for 5 stall cycles. After ready=1, div is accepted, then mul.
- Credit exhaustion: 4 mul issues with no pops → mul_can_issue_o=0 from the cycle after the 4th. One accepted mul pop → mul_can_issue_o=1 the next cycle.
- Error: with the mul FIFO full and ready=0, a 5th mul_valid_i → err_o=1 and stays 1. FIFO content is unchanged (4 entries drain in order).
- Reset mid-stream: 3 entries buffered, assert rst_n=0 for one cycle → every output at its reset value. Afterwards a fresh single mul flows with 1-cycle latency.

Source files
------------

// File: rtl/muldiv_wb_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle between the mul/div unit, the writeback arbiter and the result bus.
// Latency: none; this file only groups wires.
// Backpressure: wb_ready_i stalls the result bus; the unit side is credit-throttled.
// Ports (slave = arbiter side):
//   in : mul/div_issue_i, mul/div_valid_i, *_result_i[64], *_dest_phys_i[7], *_rob_idx_i[8], wb_ready_i
//   out: mul/div_can_issue_o, wb_valid_o, wb_result_o[64], wb_dest_phys_o[7], wb_rob_idx_o[8], wb_src_o, err_o
interface muldiv_wb_arbiter_if;
  logic        mul_issue_i;
  logic        div_issue_i;
  logic        mul_valid_i;
  logic [63:0] mul_result_i;
  logic [6:0]  mul_dest_phys_i;
  logic [7:0]  mul_rob_idx_i;
  logic        div_valid_i;
  logic [63:0] div_result_i;
  logic [6:0]  div_dest_phys_i;
  logic [7:0]  div_rob_idx_i;
  logic        mul_can_issue_o;
  logic        div_can_issue_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_result_o;
  logic [6:0]  wb_dest_phys_o;
  logic [7:0]  wb_rob_idx_o;
  logic        wb_src_o;
  logic        err_o;

  modport slave (
    input  mul_issue_i, div_issue_i,
    input  mul_valid_i, mul_result_i, mul_dest_phys_i, mul_rob_idx_i,
    input  div_valid_i, div_result_i, div_dest_phys_i, div_rob_idx_i,
    input  wb_ready_i,
    output mul_can_issue_o, div_can_issue_o,
    output wb_valid_o, wb_result_o, wb_dest_phys_o, wb_rob_idx_o, wb_src_o,
    output err_o
  );

  modport master (
    output mul_issue_i, div_issue_i,
    output mul_valid_i, mul_result_i, mul_dest_phys_i, mul_rob_idx_i,
    output div_valid_i, div_result_i, div_dest_phys_i, div_rob_idx_i,
    output wb_ready_i,
    input  mul_can_issue_o, div_can_issue_o,
    input  wb_valid_o, wb_result_o, wb_dest_phys_o, wb_rob_idx_o, wb_src_o,
    input  err_o
  );
endinterface

// File: rtl/muldiv_wb_arbiter.sv
`timescale 1ns/1ps
// Buffers mul and div results in per-source FIFOs and merges them round-robin onto one writeback port.
// Latency: arrival at cycle N is presented at N+1; one writeback per cycle while wb_ready_i is high.
// Backpressure: wb_ready_i low locks the presented entry; issue credits keep the FIFOs from overflowing.
// Ports: clk, rst_n (async active-low), bus (muldiv_wb_arbiter_if.slave; all handshake, data and status).
module muldiv_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  muldiv_wb_arbiter_if.slave     bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [63:0] result;
    logic [6:0]  dest_phys;
    logic [7:0]  rob_idx;
  } wb_entry_t;

  // Index 0 = mul, index 1 = div throughout.
  wb_entry_t     mem_q [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [2], wr_ptr_d [2];
  logic [AW-1:0] rd_ptr_q [2], rd_ptr_d [2];
  logic [CW-1:0] cnt_q [2], cnt_d [2];
  logic [CW-1:0] used_q [2], used_d [2];
  logic          lock_q, lock_d;
  logic          lock_src_q, lock_src_d;
  logic          rr_last_q, rr_last_d;
  logic          err_q, err_d;

  wb_entry_t     arr_dat [2];
  logic [1:0]    arr_vld;
  logic [1:0]    issue;
  logic [1:0]    non_empty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          sel_src;
  logic          wb_vld;
  logic          xfer;
  wb_entry_t     head;

  assign arr_vld    = {bus.div_valid_i, bus.mul_valid_i};
  assign issue      = {bus.div_issue_i, bus.mul_issue_i};
  assign arr_dat[0] = {bus.mul_result_i, bus.mul_dest_phys_i, bus.mul_rob_idx_i};
  assign arr_dat[1] = {bus.div_result_i, bus.div_dest_phys_i, bus.div_rob_idx_i};
  assign non_empty  = {cnt_q[1] != '0, cnt_q[0] != '0};

  // Selection uses only registered state, so wb_ready_i never reaches the wb_* outputs.
  always_comb begin
    sel_src = 1'b0;
    if (lock_q) begin
      sel_src = lock_src_q;
    end else if (&non_empty) begin
      sel_src = ~rr_last_q;
    end else begin
      sel_src = non_empty[1];
    end
  end

  assign wb_vld = |non_empty;
  assign xfer   = wb_vld & bus.wb_ready_i;
  assign pop    = {xfer & sel_src, xfer & ~sel_src};
  assign head   = mem_q[sel_src][rd_ptr_q[sel_src]];

  always_comb begin
    push       = '0;
    err_d      = err_q;
    lock_d     = wb_vld & ~bus.wb_ready_i;
    lock_src_d = sel_src;
    rr_last_d  = xfer ? sel_src : rr_last_q;
    for (int s = 0; s < 2; s++) begin
      // A same-cycle pop frees the slot, so a push into a full FIFO is still legal then.
      push[s] = arr_vld[s] & ((cnt_q[s] != DEPTH_C) | pop[s]);
      if (arr_vld[s] && cnt_q[s] == DEPTH_C && !pop[s]) err_d = 1'b1;
      wr_ptr_d[s] = wr_ptr_q[s] + AW'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + AW'(pop[s]);
      cnt_d[s]    = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);

      used_d[s] = used_q[s];
      if (issue[s] && !pop[s]) begin
        used_d[s] = (used_q[s] == DEPTH_C) ? used_q[s] : used_q[s] + 1'b1;
      end else if (pop[s] && !issue[s]) begin
        used_d[s] = (used_q[s] == '0) ? used_q[s] : used_q[s] - 1'b1;
      end
      if (issue[s] && used_q[s] == DEPTH_C) err_d = 1'b1;
      if (pop[s] && used_q[s] == '0) err_d = 1'b1;
    end
  end

  // Storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s]] <= arr_dat[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
        used_q[s]   <= '0;
      end
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
      rr_last_q  <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
        used_q[s]   <= used_d[s];
      end
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rr_last_q  <= rr_last_d;
      err_q      <= err_d;
    end
  end

  assign bus.wb_valid_o      = wb_vld;
  assign bus.wb_result_o     = wb_vld ? head.result : '0;
  assign bus.wb_dest_phys_o  = wb_vld ? head.dest_phys : '0;
  assign bus.wb_rob_idx_o    = wb_vld ? head.rob_idx : '0;
  assign bus.wb_src_o        = wb_vld & sel_src;
  assign bus.mul_can_issue_o = used_q[0] < DEPTH_C;
  assign bus.div_can_issue_o = used_q[1] < DEPTH_C;
  assign bus.err_o           = err_q;
endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
`timescale 1ns/1ps
// Directed bench for muldiv_wb_arbiter: reset, single flow, tie-break, lock, credits, overflow, mid-stream reset.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: wb_ready_i driven per scenario.
module tb_muldiv_wb_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muldiv_wb_arbiter_if bus ();

  muldiv_wb_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mul_issue_i     = 1'b0;
    bus.div_issue_i     = 1'b0;
    bus.mul_valid_i     = 1'b0;
    bus.mul_result_i    = '0;
    bus.mul_dest_phys_i = '0;
    bus.mul_rob_idx_i   = '0;
    bus.div_valid_i     = 1'b0;
    bus.div_result_i    = '0;
    bus.div_dest_phys_i = '0;
    bus.div_rob_idx_i   = '0;
    bus.wb_ready_i      = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 7;
    if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b exp 0", bus.wb_valid_o); end
    if (bus.wb_result_o !== 64'h0) begin errors++; $display("FAIL rst_result: got %0h exp 0", bus.wb_result_o); end
    if (bus.wb_dest_phys_o !== 7'h0 || bus.wb_rob_idx_o !== 8'h0) begin errors++; $display("FAIL rst_fields: got dest %0h rob %0h exp 0 0", bus.wb_dest_phys_o, bus.wb_rob_idx_o); end
    if (bus.wb_src_o !== 1'b0) begin errors++; $display("FAIL rst_src: got %0b exp 0", bus.wb_src_o); end
    if (bus.mul_can_issue_o !== 1'b1) begin errors++; $display("FAIL rst_mul_can: got %0b exp 1", bus.mul_can_issue_o); end
    if (bus.div_can_issue_o !== 1'b1) begin errors++; $display("FAIL rst_div_can: got %0b exp 1", bus.div_can_issue_o); end
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b exp 0", bus.err_o); end
  endtask

  task automatic test_simultaneous();
    bus.wb_ready_i = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      bus.mul_issue_i = 1'b1;
      bus.div_issue_i = 1'b1;
      tick();
      bus.mul_issue_i   = 1'b0;
      bus.div_issue_i   = 1'b0;
      bus.mul_valid_i   = 1'b1;
      bus.mul_rob_idx_i = 8'd1;
      bus.mul_result_i  = 64'hA0 + 64'(rep);
      bus.div_valid_i   = 1'b1;
      bus.div_rob_idx_i = 8'd2;
      bus.div_result_i  = 64'hB0 + 64'(rep);
      tick();
      bus.mul_valid_i = 1'b0;
      bus.div_valid_i = 1'b0;
      @(negedge clk);
      checks += 2;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_src_o !== 1'b0 || bus.wb_rob_idx_o !== 8'd1) begin errors++; $display("FAIL sim_first: got v%0b src%0b rob%0d exp v1 src0 rob1", bus.wb_valid_o, bus.wb_src_o, bus.wb_rob_idx_o); end
      if (bus.wb_result_o !== 64'hA0 + 64'(rep)) begin errors++; $display("FAIL sim_first_res: got %0h exp %0h", bus.wb_result_o, 64'hA0 + 64'(rep)); end
      tick();
      @(negedge clk);
      checks += 2;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_src_o !== 1'b1 || bus.wb_rob_idx_o !== 8'd2) begin errors++; $display("FAIL sim_second: got v%0b src%0b rob%0d exp v1 src1 rob2", bus.wb_valid_o, bus.wb_src_o, bus.wb_rob_idx_o); end
      if (bus.wb_result_o !== 64'hB0 + 64'(rep)) begin errors++; $display("FAIL sim_second_res: got %0h exp %0h", bus.wb_result_o, 64'hB0 + 64'(rep)); end
      tick();
      @(negedge clk);
      checks++;
      if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL sim_drained: got %0b exp 0", bus.wb_valid_o); end
    end
    checks++;
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL sim_err: got %0b exp 0", bus.err_o); end
  endtask

  task automatic test_lock();
    bus.wb_ready_i  = 1'b0;
    bus.mul_issue_i = 1'b1;
    bus.div_issue_i = 1'b1;
    tick();
    bus.mul_issue_i     = 1'b0;
    bus.div_issue_i     = 1'b0;
    bus.div_valid_i     = 1'b1;
    bus.div_rob_idx_i   = 8'h33;
    bus.div_dest_phys_i = 7'd7;
    bus.div_result_i    = 64'hD1D1;
    tick();
    bus.div_valid_i     = 1'b0;
    bus.mul_valid_i     = 1'b1;
    bus.mul_rob_idx_i   = 8'h44;
    bus.mul_dest_phys_i = 7'd3;
    bus.mul_result_i    = 64'h4444;
    @(negedge clk);
    checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_src_o !== 1'b1 || bus.wb_rob_idx_o !== 8'h33) begin errors++; $display("FAIL lock_first: got v%0b src%0b rob%0h exp v1 src1 rob33", bus.wb_valid_o, bus.wb_src_o, bus.wb_rob_idx_o); end
    tick();
    bus.mul_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.wb_src_o !== 1'b1 || bus.wb_rob_idx_o !== 8'h33 || bus.wb_result_o !== 64'hD1D1 || bus.wb_dest_phys_o !== 7'd7) begin errors++; $display("FAIL lock_stall%0d: got src%0b rob%0h res%0h dest%0d exp src1 rob33 resd1d1 dest7", i, bus.wb_src_o, bus.wb_rob_idx_o, bus.wb_result_o, bus.wb_dest_phys_o); end
      tick();
    end
    bus.wb_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.wb_src_o !== 1'b1 || bus.wb_rob_idx_o !== 8'h33) begin errors++; $display("FAIL lock_accept_div: got src%0b rob%0h exp src1 rob33", bus.wb_src_o, bus.wb_rob_idx_o); end
    tick();
    @(negedge clk);
    checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_src_o !== 1'b0 || bus.wb_rob_idx_o !== 8'h44 || bus.wb_result_o !== 64'h4444) begin errors++; $display("FAIL lock_then_mul: got v%0b src%0b rob%0h res%0h exp v1 src0 rob44 res4444", bus.wb_valid_o, bus.wb_src_o, bus.wb_rob_idx_o, bus.wb_result_o); end
    tick();
    @(negedge clk);
    checks++;
    if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL lock_drained: got %0b exp 0", bus.wb_valid_o); end
  endtask

  task automatic test_single_mul();
    bus.wb_ready_i  = 1'b1;
    bus.mul_issue_i = 1'b1;
    tick();
    bus.mul_issue_i     = 1'b0;
    bus.mul_valid_i     = 1'b1;
    bus.mul_result_i    = 64'h1234;
    bus.mul_dest_phys_i = 7'd5;
    bus.mul_rob_idx_i   = 8'd9;
    @(negedge clk);
    checks++;
    if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %0b exp 0", bus.wb_valid_o); end
    tick();
    bus.mul_valid_i = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_src_o !== 1'b0) begin errors++; $display("FAIL single_present: got v%0b src%0b exp v1 src0", bus.wb_valid_o, bus.wb_src_o); end
    if (bus.wb_result_o !== 64'h1234) begin errors++; $display("FAIL single_result: got %0h exp 1234", bus.wb_result_o); end
    if (bus.wb_dest_phys_o !== 7'd5 || bus.wb_rob_idx_o !== 8'd9) begin errors++; $display("FAIL single_fields: got dest%0d rob%0d exp dest5 rob9", bus.wb_dest_phys_o, bus.wb_rob_idx_o); end
    tick();
    @(negedge clk);
    checks++;
    if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL single_gone: got %0b exp 0", bus.wb_valid_o); end
  endtask

  task automatic test_credit_and_overflow();
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mul_issue_i = 1'b1;
      tick();
      bus.mul_issue_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.mul_can_issue_o !== (i < 3)) begin errors++; $display("FAIL credit_issue%0d: got %0b exp %0b", i, bus.mul_can_issue_o, i < 3); end
    end
    for (int i = 0; i < 4; i++) begin
      bus.mul_valid_i     = 1'b1;
      bus.mul_rob_idx_i   = 8'h10 + 8'(i);
      bus.mul_result_i    = 64'h100 + 64'(i);
      bus.mul_dest_phys_i = 7'(i);
      tick();
    end
    bus.mul_rob_idx_i   = 8'h99;
    bus.mul_result_i    = 64'hDEAD;
    bus.mul_dest_phys_i = 7'h7F;
    @(negedge clk);
    checks++;
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL ovf_err_before: got %0b exp 0", bus.err_o); end
    tick();
    bus.mul_valid_i = 1'b0;
    bus.wb_ready_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_rob_idx_o !== 8'h10 + 8'(i) || bus.wb_result_o !== 64'h100 + 64'(i)) begin errors++; $display("FAIL ovf_drain%0d: got v%0b rob%0h res%0h exp v1 rob%0h res%0h", i, bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_result_o, 8'h10 + 8'(i), 64'h100 + 64'(i)); end
      if (bus.err_o !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky%0d: got %0b exp 1", i, bus.err_o); end
      if (bus.mul_can_issue_o !== (i != 0)) begin errors++; $display("FAIL credit_return%0d: got %0b exp %0b", i, bus.mul_can_issue_o, i != 0); end
      tick();
    end
    @(negedge clk);
    checks += 2;
    if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b exp 0", bus.wb_valid_o); end
    if (bus.err_o !== 1'b1) begin errors++; $display("FAIL ovf_err_end: got %0b exp 1", bus.err_o); end
  endtask

  task automatic test_reset_mid_stream();
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mul_issue_i   = 1'b1;
      bus.mul_valid_i   = 1'b1;
      bus.mul_rob_idx_i = 8'h20 + 8'(i);
      bus.mul_result_i  = 64'h2000 + 64'(i);
      tick();
    end
    bus.mul_issue_i = 1'b0;
    bus.mul_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_rob_idx_o !== 8'h20) begin errors++; $display("FAIL mid_buffered: got v%0b rob%0h exp v1 rob20", bus.wb_valid_o, bus.wb_rob_idx_o); end
    rst_n = 1'b0;
    tick();
    checks += 4;
    if (bus.wb_valid_o !== 1'b0 || bus.wb_src_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got v%0b src%0b exp v0 src0", bus.wb_valid_o, bus.wb_src_o); end
    if (bus.wb_result_o !== 64'h0 || bus.wb_dest_phys_o !== 7'h0 || bus.wb_rob_idx_o !== 8'h0) begin errors++; $display("FAIL mid_rst_fields: got res%0h dest%0h rob%0h exp 0 0 0", bus.wb_result_o, bus.wb_dest_phys_o, bus.wb_rob_idx_o); end
    if (bus.mul_can_issue_o !== 1'b1 || bus.div_can_issue_o !== 1'b1) begin errors++; $display("FAIL mid_rst_can: got mul%0b div%0b exp 1 1", bus.mul_can_issue_o, bus.div_can_issue_o); end
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %0b exp 0", bus.err_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL mid_post_empty: got %0b exp 0", bus.wb_valid_o); end
    bus.wb_ready_i  = 1'b1;
    bus.mul_issue_i = 1'b1;
    tick();
    bus.mul_issue_i     = 1'b0;
    bus.mul_valid_i     = 1'b1;
    bus.mul_rob_idx_i   = 8'h55;
    bus.mul_result_i    = 64'hBEEF;
    bus.mul_dest_phys_i = 7'h12;
    tick();
    bus.mul_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_src_o !== 1'b0 || bus.wb_rob_idx_o !== 8'h55 || bus.wb_result_o !== 64'hBEEF || bus.wb_dest_phys_o !== 7'h12) begin errors++; $display("FAIL mid_fresh: got v%0b src%0b rob%0h res%0h dest%0h exp v1 src0 rob55 resbeef dest12", bus.wb_valid_o, bus.wb_src_o, bus.wb_rob_idx_o, bus.wb_result_o, bus.wb_dest_phys_o); end
    tick();
    @(negedge clk);
    checks += 2;
    if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL mid_fresh_gone: got %0b exp 0", bus.wb_valid_o); end
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL mid_fresh_err: got %0b exp 0", bus.err_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    tick();
    rst_n = 1'b1;
    test_simultaneous();
    test_lock();
    test_single_mul();
    test_credit_and_overflow();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
